// File: rtl/decode_operand_stage_if.sv
// Bus bundle for the decode/operand-fetch stage: instruction in,
// ALU operands out, and writeback from the consuming stage.
interface decode_operand_stage_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [15:0]       in_instr;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] immv;
    logic [3:0]        alu_control;
    logic [2:0]        out_rd;
    logic              out_we;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic              wb_en;
    logic [2:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  in_valid, in_instr, out_ready,
        input  wb_en, wb_addr, wb_data,
        output in_ready, out_valid,
        output a, b, immv, alu_control,
        output out_rd, out_we, out_mem_rd, out_mem_wr
    );

    modport master (
        output in_valid, in_instr, out_ready,
        output wb_en, wb_addr, wb_data,
        input  in_ready, out_valid,
        input  a, b, immv, alu_control,
        input  out_rd, out_we, out_mem_rd, out_mem_wr
    );
endinterface

// File: rtl/decode_operand_stage.sv
// Decode/operand-fetch stage in front of the 8-bit ALU: owns the register
// file, tracks in-flight destinations and stalls on RAW/WAW hazards.
module decode_operand_stage #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] REG_INIT = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_operand_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] immv;
        logic [3:0]        alu_control;
        logic [2:0]        rd;
        logic              we;
        logic              mem_rd;
        logic              mem_wr;
    } id_ex_t;

    logic [DATA_W-1:0] rf [8];
    logic [7:0]        pending;
    logic [7:0]        wb_hit;
    logic [7:0]        eff;
    logic [7:0]        set_mask;

    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;

    logic is_reg;
    logic is_mr;
    logic is_imm;
    logic is_mi;
    logic is_ld;
    logic is_st;
    logic rd_use;
    logic rs_use;
    logic we;

    logic hazard;
    logic slot_free;
    logic accept;

    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;

    id_ex_t out_q;
    id_ex_t out_d;
    logic   out_valid_q;

    assign op = bus.in_instr[15:12];
    assign rd = bus.in_instr[11:9];
    assign rs = bus.in_instr[8:6];

    assign is_reg = (op == 4'b0100) || (op == 4'b0101) ||
                    (op == 4'b0111) || (op == 4'b0110) ||
                    (op == 4'b1000) || (op == 4'b1010);
    assign is_mr  = (op == 4'b0011);
    assign is_imm = (op == 4'b1100) || (op == 4'b1101) ||
                    (op == 4'b1111) || (op == 4'b1110) ||
                    (op == 4'b1001) || (op == 4'b1011);
    assign is_mi  = (op == 4'b0010);
    assign is_ld  = (op == 4'b0000);
    assign is_st  = (op == 4'b0001);

    always_comb begin
        rd_use = 1'b0;
        rs_use = 1'b0;
        unique case (1'b1)
            is_reg: begin
                rd_use = 1'b1;
                rs_use = 1'b1;
            end
            is_mr:  rs_use = 1'b1;
            is_imm: rd_use = 1'b1;
            is_st:  rd_use = 1'b1;
            is_mi:  ;
            is_ld:  ;
            default: ;
        endcase
    end

    assign we = !is_st;

    // A writeback landing this cycle both releases the hazard and bypasses
    // its data, so the consumer is accepted in the same cycle.
    always_comb begin
        wb_hit = '0;
        if (bus.wb_en) wb_hit[bus.wb_addr] = 1'b1;
    end

    assign eff = pending & ~wb_hit;

    assign hazard = bus.in_valid &&
                    ((rd_use && eff[rd]) ||
                     (rs_use && eff[rs]) ||
                     (we && eff[rd]));

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = slot_free && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    assign rd_val = wb_hit[rd] ? bus.wb_data : rf[rd];
    assign rs_val = wb_hit[rs] ? bus.wb_data : rf[rs];

    always_comb begin
        out_d             = '0;
        out_d.a           = rd_val;
        out_d.b           = rs_val;
        out_d.immv        = bus.in_instr[DATA_W-1:0];
        out_d.alu_control = op;
        out_d.rd          = rd;
        out_d.we          = we;
        out_d.mem_rd      = is_ld;
        out_d.mem_wr      = is_st;
    end

    always_comb begin
        set_mask = '0;
        if (accept && we) set_mask[rd] = 1'b1;
    end

    // Set is ORed after the clear so a same-cycle set on a register wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= REG_INIT;
            pending     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (bus.wb_en) rf[bus.wb_addr] <= bus.wb_data;
            pending <= (pending & ~wb_hit) | set_mask;
            if (accept) begin
                out_q       <= out_d;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.a           = out_q.a;
    assign bus.b           = out_q.b;
    assign bus.immv        = out_q.immv;
    assign bus.alu_control = out_q.alu_control;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_we      = out_q.we;
    assign bus.out_mem_rd  = out_q.mem_rd;
    assign bus.out_mem_wr  = out_q.mem_wr;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Scoreboard bench for decode_operand_stage: directed sequence followed by
// random traffic checked against a register/pending-set reference model.
module tb_decode_operand_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_operand_stage_if #(.DATA_W(8)) bus ();

    decode_operand_stage #(
        .DATA_W  (8),
        .REG_INIT(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] immv;
        logic [3:0] op;
        logic [2:0] rd;
        logic       we;
        logic       ld;
        logic       st;
    } exp_t;

    exp_t       q[$];
    logic [7:0] regs [8];
    bit         pend [8];
    bit         mvalid;
    bit         mon_en;
    bit         post_rst;
    int         n_checks;
    int         n_fail;

    function automatic bit reads_rd(input logic [3:0] op);
        return op inside {4'h4, 4'h5, 4'h7, 4'h6, 4'h8, 4'hA,
                          4'hC, 4'hD, 4'hF, 4'hE, 4'h9, 4'hB, 4'h1};
    endfunction

    function automatic bit reads_rs(input logic [3:0] op);
        return op inside {4'h4, 4'h5, 4'h7, 4'h6, 4'h8, 4'hA, 4'h3};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (bus.out_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL out_valid: got %b expected %b",
                         bus.out_valid, q.size() != 0);
            end
            if (bus.out_valid === 1'b1 && q.size() != 0) begin
                exp_t got;
                got = {bus.a, bus.b, bus.immv, bus.alu_control,
                       bus.out_rd, bus.out_we, bus.out_mem_rd, bus.out_mem_wr};
                n_checks++;
                if (got !== q[0]) begin
                    n_fail++;
                    $display("FAIL outputs: got a=%h b=%h imm=%h op=%h rd=%0d we=%b ld=%b st=%b expected a=%h b=%h imm=%h op=%h rd=%0d we=%b ld=%b st=%b",
                             got.a, got.b, got.immv, got.op, got.rd, got.we, got.ld, got.st,
                             q[0].a, q[0].b, q[0].immv, q[0].op, q[0].rd, q[0].we, q[0].ld, q[0].st);
                end
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] ins,
                        input logic ordy, input logic wen,
                        input logic [2:0] wa, input logic [7:0] wd,
                        input logic r);
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        bit         eff [8];
        bit         hz;
        bit         exp_ready;
        bit         acc;
        exp_t       e;
        @(posedge clk);
        #1;
        if (post_rst) begin
            n_checks++;
            if ({bus.out_valid, bus.a, bus.b, bus.immv, bus.alu_control,
                 bus.out_rd, bus.out_we, bus.out_mem_rd, bus.out_mem_wr} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got valid=%b a=%h b=%h imm=%h op=%h rd=%0d we=%b ld=%b st=%b expected all zero",
                         bus.out_valid, bus.a, bus.b, bus.immv, bus.alu_control,
                         bus.out_rd, bus.out_we, bus.out_mem_rd, bus.out_mem_wr);
            end
            post_rst = 0;
        end
        rst           = r;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.wb_en     = wen;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        @(negedge clk);
        #1;
        if (r) begin
            q.delete();
            mvalid = 0;
            for (int i = 0; i < 8; i++) begin
                regs[i] = 8'h00;
                pend[i] = 0;
            end
            post_rst = 1;
            return;
        end
        op = ins[15:12];
        rd = ins[11:9];
        rs = ins[8:6];
        for (int i = 0; i < 8; i++) eff[i] = pend[i] && !(wen && wa == i);
        hz = v && ((reads_rd(op) && eff[rd]) || (reads_rs(op) && eff[rs]) ||
                   (op != 4'h1 && eff[rd]));
        exp_ready = (!mvalid || ordy) && !hz;
        n_checks++;
        if (bus.in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL in_ready: instr=%h got %b expected %b",
                     ins, bus.in_ready, exp_ready);
        end
        acc = v && exp_ready;
        if (acc) begin
            e.a    = (wen && wa == rd) ? wd : regs[rd];
            e.b    = (wen && wa == rs) ? wd : regs[rs];
            e.immv = ins[7:0];
            e.op   = op;
            e.rd   = rd;
            e.we   = (op != 4'h1);
            e.ld   = (op == 4'h0);
            e.st   = (op == 4'h1);
            q.push_back(e);
        end
        if (acc) mvalid = 1;
        else if (ordy) mvalid = 0;
        if (wen) begin
            regs[wa] = wd;
            pend[wa] = 0;
        end
        if (acc && op != 4'h1) pend[rd] = 1;
    endtask

    initial begin
        logic [2:0] wa;
        bus.in_valid  = 0;
        bus.in_instr  = '0;
        bus.out_ready = 0;
        bus.wb_en     = 0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        step(0, 16'h0, 1, 0, 0, 8'h0, 1);
        step(0, 16'h0, 1, 0, 0, 8'h0, 1);
        mon_en = 1;
        // writeback seeds, SUM, then stalled SMI released by bypass
        step(0, 16'h0000, 1, 1, 3'd1, 8'h05, 0);
        step(0, 16'h0000, 1, 1, 3'd2, 8'h03, 0);
        step(1, 16'h4280, 1, 0, 0, 8'h00, 0);
        step(1, 16'hC20A, 1, 0, 0, 8'h00, 0);
        step(1, 16'hC20A, 1, 0, 0, 8'h00, 0);
        step(1, 16'hC20A, 1, 1, 3'd1, 8'h08, 0);
        // downstream backpressure with a waiting instruction
        step(1, 16'h2A11, 0, 1, 3'd1, 8'h22, 0);
        step(1, 16'h2A11, 0, 0, 0, 8'h00, 0);
        step(1, 16'h2A11, 0, 0, 0, 8'h00, 0);
        step(1, 16'h2A11, 1, 0, 0, 8'h00, 0);
        // store then move-register consumer of the stored register
        step(1, 16'h1600, 1, 0, 0, 8'h00, 0);
        step(1, 16'h38C0, 1, 0, 0, 8'h00, 0);
        // reset with output held and a pending destination
        step(1, 16'h2400, 0, 0, 0, 8'h00, 0);
        step(0, 16'h0000, 0, 0, 0, 8'h00, 1);
        step(1, 16'h4000, 1, 0, 0, 8'h00, 0);
        // move-immediate accepted alongside writeback to its destination
        step(1, 16'h2A00, 1, 1, 3'd5, 8'h77, 0);
        step(1, 16'hDA01, 1, 0, 0, 8'h00, 0);
        step(1, 16'hDA01, 1, 1, 3'd5, 8'h10, 0);
        step(0, 16'h0000, 1, 1, 3'd0, 8'h00, 0);
        for (int n = 0; n < 3000; n++) begin
            wa = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    if (pend[(int'(wa) + k) % 8]) begin
                        wa = 3'((int'(wa) + k) % 8);
                        break;
                    end
                end
            end
            step($urandom_range(0, 3) != 0,
                 16'($urandom()),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 wa,
                 8'($urandom()),
                 $urandom_range(0, 299) == 0);
        end
        step(0, 16'h0000, 1, 0, 0, 8'h00, 0);
        step(0, 16'h0000, 1, 0, 0, 8'h00, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the 8-bit ALU.
- Accepts a 16-bit instruction and reads an 8-entry x 8-bit register file, which it owns.
- Drives the ALU inputs from an output register: a, b, immv, alu_control, plus destination and memory-op tags.
- A 1-bit-per-register scoreboard with writeback bypass stalls on read-after-write (RAW) and write-after-write (WAW) hazards until the consuming stage writes back.

Parameters:
- DATA_W, 8, register and operand width; only 8 is supported.
- REG_INIT, 8'h00, reset value of every register-file entry.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_instr  in  16  instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- out_valid  out  1  decoded operands valid for the ALU.
- out_ready  in  1  downstream consumes the current output.
- a  out  8  operand 1 = R[rd].
- b  out  8  operand 2 = R[rs].
- immv  out  8  immediate, instr[7:0].
- alu_control  out  4  opcode, instr[15:12].
- out_rd  out  3  destination register.
- out_we  out  1  instruction writes rd back.
- out_mem_rd  out  1  LD (opcode 0000).
- out_mem_wr  out  1  ST (opcode 0001).
- wb_en  in  1  writeback strobe from the downstream stage.
- wb_addr  in  3  writeback register.
- wb_data  in  8  writeback value.

Behaviour:
- Instruction format: op = [15:12], rd = [11:9], rs = [8:6], imm = [7:0]. Immediate forms ignore rs.
- Opcode classes:
  - Register-form (reads rd and rs): 0100 SUM, 0101 SB, 0111 CM, 0110 ANR, 1000 ORR, 1010 XRR.
  - MR 0011: reads rs only.
  - Immediate-form (reads rd): 1100, 1101, 1111, 1110, 1001, 1011.
  - MI 0010: reads nothing.
  - LD 0000: reads nothing; address = imm; out_we = 1.
  - ST 0001: reads rd as data; out_we = 0.
- out_we = 1 for every opcode except ST.
- Reset (rst high at a clock edge):
  - All registers = REG_INIT; scoreboard cleared.
  - out_valid, a, b, immv, alu_control, out_rd, out_we, out_mem_rd, out_mem_wr = 0.
  - rst mid-operation discards the held output and all pending bits. wb_en is ignored in the reset cycle.
- Register file write: on wb_en, R[wb_addr] <= wb_data at the clock edge.
- Bypass: a read of a register equal to wb_addr while wb_en is high in the same cycle returns wb_data, not the stale entry.
- Scoreboard:
  - pending[r] is set when an accepted instruction has out_we = 1 and rd = r.
  - pending[r] is cleared on wb_en with wb_addr = r.
  - If a set and a clear hit the same register in one cycle, the set wins.
- Effective pending: eff[r] = pending[r] && !(wb_en && wb_addr == r).
- Hazard: in_valid and any of the following:
  - A register read by the opcode has eff = 1.
  - out_we = 1 and eff[rd] = 1 (WAW).
- Handshake:
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && !hazard. in_ready is combinational and depends on in_instr only when in_valid = 1.
  - Accept = in_valid && in_ready. On accept, the output register loads the decoded fields and out_valid <= 1.
  - Otherwise, if out_ready && out_valid, then out_valid <= 0.
  - While out_valid && !out_ready, all outputs hold stable.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 instruction per cycle when there is no hazard and out_ready = 1.
- Operands for unused slots are still driven from the register file, but they do not participate in the hazard check.

Test Plan:
1. Reset, then wb writes R1 = 8'h05 and R2 = 8'h03; issue SUM rd=1, rs=2 (16'h4280) -> next cycle out_valid = 1, a = 05, b = 03, alu_control = 4'b0100, out_rd = 1, out_we = 1; pending[1] = 1.
2. Immediately issue SMI rd=1, imm = 8'h0A -> in_ready = 0 while pending[1]. Then wb_en with R1 = 8'h08 -> the same cycle accepts, and a = 08 via bypass, immv = 0A.
3. Hold out_ready = 0 for 3 cycles with a second valid instruction waiting -> outputs stable, in_ready = 0. Raise out_ready -> second instruction loads the next cycle.
4. ST rd=3 (16'h1600) -> out_mem_wr = 1, out_we = 0, no scoreboard bit set. A following MR rd=4, rs=3 is accepted without stall.
5. Assert rst while out_valid = 1 and pending[2] = 1 -> next cycle out_valid = 0, all outputs 0, scoreboard clear, R0–R7 = 00.
6. Same-cycle accept of MI rd=5 while wb_en, wb_addr = 5 -> R5 takes wb_data, and pending[5] remains 1 (set wins).
